// File: rtl/msrv32_defines.sv
// msrv32_defines: shared size codes, LSU state encoding and bus width for the load/store unit.
package msrv32_defines;
    localparam int BUS_W = 32;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;
endpackage

// File: rtl/msrv32_lsu_align.sv
// msrv32_lsu_align: store lane replication/byte mask, load lane extraction/extension, misalignment check.
module msrv32_lsu_align
    import msrv32_defines::*;
(
    input  logic [1:0]       i_st_size,
    input  logic [1:0]       i_st_off,
    input  logic [BUS_W-1:0] i_rs2,
    output logic [BUS_W-1:0] o_wr_data,
    output logic [3:0]       o_mask,
    output logic             o_misaligned,
    input  logic [1:0]       i_ld_size,
    input  logic [1:0]       i_ld_off,
    input  logic             i_ld_uns,
    input  logic [BUS_W-1:0] i_rd_data,
    output logic [BUS_W-1:0] o_ld_data
);
    logic [7:0]  w_b;
    logic [15:0] w_h;
    assign o_wr_data = (i_st_size == SZ_BYTE) ? {4{i_rs2[7:0]}} :
                       (i_st_size == SZ_HALF) ? {2{i_rs2[15:0]}} : i_rs2;
    assign o_mask    = (i_st_size == SZ_BYTE) ? 4'b0001 << i_st_off :
                       (i_st_size == SZ_HALF) ? 4'b0011 << {i_st_off[1], 1'b0} : 4'b1111;
    // Size 2'b11 shares the word rule, hence the test on bit 1 alone.
    assign o_misaligned = ((i_st_size == SZ_HALF) & i_st_off[0]) | (i_st_size[1] & (i_st_off != 2'b00));
    assign w_b = i_rd_data[{i_ld_off, 3'b000} +: 8];
    assign w_h = i_ld_off[1] ? i_rd_data[31:16] : i_rd_data[15:0];
    assign o_ld_data = (i_ld_size == SZ_BYTE) ? {{24{~i_ld_uns & w_b[7]}}, w_b} :
                       (i_ld_size == SZ_HALF) ? {{16{~i_ld_uns & w_h[15]}}, w_h} : i_rd_data;
endmodule

// File: rtl/msrv32_lsu.sv
// msrv32_lsu: stage-3 load/store unit; drives the data bus with req/ack, stalls the pipeline,
// returns extended load data and flags misalignment and bus timeouts.
module msrv32_lsu
    import msrv32_defines::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = BUS_W
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              mem_rd_req_in,
    input  logic              mem_wr_req_in,
    input  logic [31:0]       iadder_out_reg_in,
    input  logic [31:0]       rs2_reg_in,
    input  logic [1:0]        load_size_reg_in,
    input  logic              load_unsigned_reg_in,
    output logic [ADDR_W-1:0] dbus_addr_out,
    output logic [31:0]       dbus_wr_data_out,
    output logic [3:0]        dbus_wr_mask_out,
    output logic              dbus_rd_req_out,
    output logic              dbus_wr_req_out,
    input  logic              dbus_ack_in,
    input  logic [31:0]       dbus_rd_data_in,
    output logic              lsu_stall_out,
    output logic [31:0]       load_data_out,
    output logic              load_valid_out,
    output logic              misaligned_out,
    output logic              bus_error_out
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    lsu_state_e    r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_off, r_size;
    logic          r_uns;
    logic          w_req, w_mis, w_start, w_timeout, w_done;
    logic [31:0]   w_wr_data, w_ld_data;
    logic [3:0]    w_mask;

    msrv32_lsu_align u_align (
        .i_st_size    (load_size_reg_in),
        .i_st_off     (iadder_out_reg_in[1:0]),
        .i_rs2        (rs2_reg_in),
        .o_wr_data    (w_wr_data),
        .o_mask       (w_mask),
        .o_misaligned (w_mis),
        .i_ld_size    (r_size),
        .i_ld_off     (r_off),
        .i_ld_uns     (r_uns),
        .i_rd_data    (dbus_rd_data_in),
        .o_ld_data    (w_ld_data)
    );

    // Gating with reset keeps stall low while reset is held even if the request inputs are still up.
    assign w_req          = mem_rd_req_in | mem_wr_req_in;
    assign w_start        = ~reset_in & (r_state == ST_IDLE) & w_req & ~w_mis;
    assign misaligned_out = ~reset_in & (r_state == ST_IDLE) & w_req & w_mis;
    assign lsu_stall_out  = w_start | (r_state == ST_BUSY);
    assign w_timeout      = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_done         = (r_state == ST_BUSY) & (dbus_ack_in | w_timeout);

    always_comb begin
        w_next = (r_state == ST_IDLE) ? (w_start ? ST_BUSY : ST_IDLE) :
                 (r_state == ST_BUSY) ? (w_done ? ST_RESP : ST_BUSY) : ST_IDLE;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_cnt            <= '0;
            r_off            <= 2'b00;
            r_size           <= 2'b00;
            r_uns            <= 1'b0;
            dbus_addr_out    <= '0;
            dbus_wr_data_out <= '0;
            dbus_wr_mask_out <= 4'b0000;
            dbus_rd_req_out  <= 1'b0;
            dbus_wr_req_out  <= 1'b0;
            load_data_out    <= '0;
            load_valid_out   <= 1'b0;
            bus_error_out    <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + CW'(1);
            load_valid_out <= 1'b0;
            bus_error_out  <= 1'b0;
            if (w_start) begin
                r_cnt            <= '0;
                r_off            <= iadder_out_reg_in[1:0];
                r_size           <= load_size_reg_in;
                r_uns            <= load_unsigned_reg_in;
                dbus_addr_out    <= {iadder_out_reg_in[ADDR_W-1:2], 2'b00};
                dbus_wr_data_out <= w_wr_data;
                dbus_wr_mask_out <= w_mask;
                dbus_rd_req_out  <= ~mem_wr_req_in;
                dbus_wr_req_out  <= mem_wr_req_in;
            end
            if (w_done) begin
                dbus_rd_req_out <= 1'b0;
                dbus_wr_req_out <= 1'b0;
                bus_error_out   <= ~dbus_ack_in;
                if (dbus_ack_in & dbus_rd_req_out) begin
                    load_data_out  <= w_ld_data;
                    load_valid_out <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_msrv32_lsu.sv
// tb_msrv32_lsu: directed transactions checked every cycle against a transaction-level model.
module tb_msrv32_lsu;
    localparam int TO = 4;
    logic        clk_in = 1'b0, reset_in = 1'b1;
    logic        mem_rd_req_in = 0, mem_wr_req_in = 0, load_unsigned_reg_in = 0, dbus_ack_in = 0;
    logic [31:0] iadder_out_reg_in = 0, rs2_reg_in = 0, dbus_rd_data_in = 0;
    logic [1:0]  load_size_reg_in = 0;
    logic [31:0] dbus_addr_out, dbus_wr_data_out, load_data_out;
    logic [3:0]  dbus_wr_mask_out;
    logic        dbus_rd_req_out, dbus_wr_req_out, lsu_stall_out, load_valid_out, misaligned_out, bus_error_out;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ld = 0;
    logic [3:0]  e_mask = 0;
    logic        e_rd = 0, e_wr = 0, e_stall = 0, e_lv = 0, e_mis = 0, e_err = 0;
    logic        chk_en = 1'b1;
    logic [31:0] s_wdata = 0;
    logic [3:0]  s_mask = 0;
    int          n_tests = 0, n_fail = 0;

    msrv32_lsu #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .mem_rd_req_in(mem_rd_req_in), .mem_wr_req_in(mem_wr_req_in),
        .iadder_out_reg_in(iadder_out_reg_in), .rs2_reg_in(rs2_reg_in),
        .load_size_reg_in(load_size_reg_in), .load_unsigned_reg_in(load_unsigned_reg_in),
        .dbus_addr_out(dbus_addr_out), .dbus_wr_data_out(dbus_wr_data_out),
        .dbus_wr_mask_out(dbus_wr_mask_out), .dbus_rd_req_out(dbus_rd_req_out),
        .dbus_wr_req_out(dbus_wr_req_out), .dbus_ack_in(dbus_ack_in),
        .dbus_rd_data_in(dbus_rd_data_in), .lsu_stall_out(lsu_stall_out),
        .load_data_out(load_data_out), .load_valid_out(load_valid_out),
        .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [1:0] off,
                                             input logic [1:0] sz, input logic u);
        logic [31:0] v;
        int n = nbytes(sz);
        int sh = 8 * ((off / n) * n);
        if (n == 4) return d;
        v = (d >> sh) & ((32'd1 << (8 * n)) - 1);
        if (!u && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] sz);
        int n = nbytes(sz);
        return (n == 1) ? (d & 32'hFF) * 32'h0101_0101 : (n == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] off, input logic [1:0] sz);
        int n = nbytes(sz);
        return 4'(((1 << n) - 1) << ((off / n) * n));
    endfunction

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("dbus_addr", dbus_addr_out, e_addr);
            check("wr_data", dbus_wr_data_out, e_wdata);
            check("wr_mask", {28'd0, dbus_wr_mask_out}, {28'd0, e_mask});
            check("rd_req", {31'd0, dbus_rd_req_out}, {31'd0, e_rd});
            check("wr_req", {31'd0, dbus_wr_req_out}, {31'd0, e_wr});
            check("stall", {31'd0, lsu_stall_out}, {31'd0, e_stall});
            check("load_data", load_data_out, e_ld);
            check("load_valid", {31'd0, load_valid_out}, {31'd0, e_lv});
            check("misaligned", {31'd0, misaligned_out}, {31'd0, e_mis});
            check("bus_error", {31'd0, bus_error_out}, {31'd0, e_err});
        end
    end

    task automatic drop_inputs();
        mem_rd_req_in = 0; mem_wr_req_in = 0; iadder_out_reg_in = 0; rs2_reg_in = 0;
        load_size_reg_in = 0; load_unsigned_reg_in = 0; dbus_ack_in = 0; dbus_rd_data_in = 0;
    endtask

    // k = bus cycle (1-based) carrying the ack; 0 means no ack, so the access times out.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [1:0] sz, input logic u, input int k, input logic [31:0] rdata);
        logic mis = (int'(addr[1:0]) % nbytes(sz)) != 0;
        logic is_ld = rd & ~wr;
        @(posedge clk_in); #1;
        mem_rd_req_in = rd; mem_wr_req_in = wr; iadder_out_reg_in = addr; rs2_reg_in = rs2;
        load_size_reg_in = sz; load_unsigned_reg_in = u;
        e_mis = mis; e_stall = ~mis; e_lv = 0; e_err = 0;
        if (mis) begin
            @(posedge clk_in); #1;
            drop_inputs();
            e_mis = 0; e_stall = 0;
            return;
        end
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk_in); #1;
            e_addr = addr & ~32'd3; e_wdata = exp_wdata(rs2, sz); e_mask = exp_mask(addr[1:0], sz);
            e_rd = is_ld; e_wr = wr; e_stall = 1;
            dbus_ack_in = (c == k);
            dbus_rd_data_in = (c == k) ? rdata : 32'h5A5A_5A5A;
            @(negedge clk_in);
            if (c == 1) begin s_wdata = dbus_wr_data_out; s_mask = dbus_wr_mask_out; end
            if (c == k || (k == 0 && c == TO)) break;
        end
        @(posedge clk_in); #1;
        dbus_ack_in = 0;
        e_rd = 0; e_wr = 0; e_stall = 0;
        if (k != 0 && is_ld) begin e_lv = 1; e_ld = exp_load(rdata, addr[1:0], sz, u); end
        e_err = (k == 0);
        @(posedge clk_in); #1;
        drop_inputs();
        e_lv = 0; e_err = 0;
    endtask

    initial begin
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        reset_in = 0;
        access(1, 0, 32'h1000_0008, 0, 2'd2, 0, 2, 32'hDEAD_BEEF);
        check("lw_literal", load_data_out, 32'hDEAD_BEEF);
        access(1, 0, 32'h1000_0003, 0, 2'd0, 0, 1, 32'h80FF_0000);
        check("lb_signed_literal", load_data_out, 32'hFFFF_FF80);
        access(1, 0, 32'h1000_0003, 0, 2'd0, 1, 1, 32'h80FF_0000);
        check("lbu_literal", load_data_out, 32'h0000_0080);
        access(1, 0, 32'h2000_0006, 0, 2'd1, 0, 3, 32'h8001_1234);
        check("lh_signed_literal", load_data_out, 32'hFFFF_8001);
        access(1, 0, 32'h2000_0004, 0, 2'd1, 1, 2, 32'h8001_F234);
        check("lhu_literal", load_data_out, 32'h0000_F234);
        access(1, 0, 32'h3000_000C, 0, 2'd3, 0, 1, 32'h0123_4567);
        access(0, 1, 32'h1000_0002, 32'h1234_ABCD, 2'd1, 0, 3, 32'h0);
        check("sh_data_literal", s_wdata, 32'hABCD_ABCD);
        check("sh_mask_literal", {28'd0, s_mask}, 32'h0000_000C);
        check("sh_no_load_literal", load_data_out, 32'h0123_4567);
        access(0, 1, 32'h1000_0001, 32'h0000_0055, 2'd0, 0, 1, 32'h0);
        check("sb_data_literal", s_wdata, 32'h5555_5555);
        check("sb_mask_literal", {28'd0, s_mask}, 32'h0000_0002);
        access(1, 1, 32'h4000_0004, 32'hCAFE_F00D, 2'd2, 0, 2, 32'hFFFF_FFFF);
        access(1, 0, 32'h1000_0001, 0, 2'd2, 0, 1, 32'h0);
        access(1, 0, 32'h1000_0003, 0, 2'd1, 0, 1, 32'h0);
        access(0, 1, 32'h1000_0002, 32'h1, 2'd2, 0, 1, 32'h0);
        access(1, 0, 32'h5000_0010, 0, 2'd2, 0, 0, 32'h0);
        @(posedge clk_in); #1;
        dbus_ack_in = 1; dbus_rd_data_in = 32'h1111_1111;
        @(posedge clk_in); #1;
        dbus_ack_in = 0;
        access(1, 0, 32'h0000_0020, 0, 2'd2, 0, 0, 32'h0);
        @(posedge clk_in); #1;
        mem_rd_req_in = 1; iadder_out_reg_in = 32'h0000_0040; load_size_reg_in = 2'd2;
        e_stall = 1;
        @(posedge clk_in); #1;
        e_addr = 32'h0000_0040; e_mask = 4'hF; e_wdata = 0; e_rd = 1;
        @(posedge clk_in); #2;
        chk_en = 0;
        reset_in = 1;
        #1;
        check("rst_rd_req", {31'd0, dbus_rd_req_out}, 32'd0);
        check("rst_wr_req", {31'd0, dbus_wr_req_out}, 32'd0);
        check("rst_stall", {31'd0, lsu_stall_out}, 32'd0);
        check("rst_load_data", load_data_out, 32'd0);
        e_addr = 0; e_wdata = 0; e_mask = 0; e_rd = 0; e_wr = 0; e_stall = 0; e_ld = 0;
        drop_inputs();
        @(posedge clk_in); #1;
        reset_in = 0; chk_en = 1;
        @(posedge clk_in); #1;
        dbus_ack_in = 1; dbus_rd_data_in = 32'h7777_7777;
        @(posedge clk_in); #1;
        dbus_ack_in = 0;
        repeat (3) @(posedge clk_in);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/msrv32_lsu.md
Name: msrv32_lsu

Overview:
- Stage-3 load/store unit, directly downstream of the stage-2 pipeline register.
- Consumes that register's effective address (iadder_out), store data (rs2), load size and load-unsigned outputs, plus registered load/store request flags.
- Drives the data-memory bus with a req/ack handshake and stalls the pipeline until the access completes.
- Returns aligned, sign- or zero-extended load data to the writeback mux, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: number of BUSY cycles without ack before the access aborts; 0 disables the timeout.
- ADDR_W, 32: bus address width.

Ports:
- clk_in  in  1  system clock, rising edge.
- reset_in  in  1  reset, asynchronous, active-high.
- mem_rd_req_in  in  1  registered instruction is a load.
- mem_wr_req_in  in  1  registered instruction is a store.
- iadder_out_reg_in  in  32  effective byte address.
- rs2_reg_in  in  32  store source data.
- load_size_reg_in  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- load_unsigned_reg_in  in  1  zero-extend load result.
- dbus_addr_out  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- dbus_wr_data_out  out  32  lane-replicated store data.
- dbus_wr_mask_out  out  4  byte enables.
- dbus_rd_req_out  out  1  read request.
- dbus_wr_req_out  out  1  write request.
- dbus_ack_in  in  1  bus completion.
- dbus_rd_data_in  in  32  read data, valid with ack.
- lsu_stall_out  out  1  hold the stage-2 register and PC.
- load_data_out  out  32  extended load result.
- load_valid_out  out  1  load_data_out valid this cycle.
- misaligned_out  out  1  misaligned access (to trap logic).
- bus_error_out  out  1  access timed out.

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE, the counter clears, and every output reg goes to 0. A reset during BUSY drops the bus request immediately; there is no completion.
- States: IDLE, BUSY, RESP. Encoding is 2 bits.
- IDLE, no request: outputs idle; dbus_ack_in is ignored.
- IDLE, request, misaligned (half with addr[0]=1, or word with addr[1:0]!=0):
  - misaligned_out is driven combinationally this cycle.
  - No bus request; stall is 0; state stays IDLE.
- IDLE, request, aligned:
  - lsu_stall_out is driven combinationally high.
  - On the clock edge, register addr, data, mask and req; go to BUSY; clear the counter.
- Both mem_rd_req_in and mem_wr_req_in high: the store wins and the load is ignored.
- Store lanes:
  - byte: data {4{rs2[7:0]}}, mask 4'b0001<<addr[1:0].
  - half: data {2{rs2[15:0]}}, mask 4'b0011<<{addr[1],1'b0}.
  - word: data rs2, mask 4'b1111.
  - Loads drive the same mask.
- BUSY:
  - lsu_stall_out=1; all bus outputs held stable.
  - On dbus_ack_in: capture the lane selected by addr[1:0], extend per size/unsigned into load_data_out, and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no ack (parameter nonzero): go to RESP with the error flag set.
- RESP (1 cycle):
  - bus req = 0; lsu_stall_out = 0.
  - Loads: load_valid_out=1 and load_data_out stable.
  - Timeout: bus_error_out=1 and load_valid_out=0.
  - The request inputs are still present for the same instruction and are ignored. Next state is IDLE.
- Latency: the request is seen in cycle 0; bus req is visible from cycle 1; with ack in cycle k≥1, RESP is cycle k+1. Minimum 3 cycles; a store stalls the pipeline for at least 2.
- An ack arriving in IDLE or RESP is ignored.
- load_data_out holds its value until the next load completes.

Decomposition:
- Shared package/header msrv32_defines: size codes (BYTE/HALF/WORD), LSU state encodings, and the bus width constant.
- One combinational sub-module, msrv32_lsu_align:
  - store path: store-data replication and byte-mask generation from size/addr[1:0];
  - load path: load lane extraction and sign/zero extension;
  - misaligned detection.
- msrv32_lsu keeps the FSM, timeout counter and output registers.

Test Plan:
- Load word, addr 0x1000_0008, ack 2 cycles after req, rd_data 0xDEAD_BEEF:
  - dbus_addr 0x1000_0008, rd_req=1 for 2 cycles, stall high for 3 cycles;
  - then load_valid=1 with load_data 0xDEAD_BEEF.
- Load byte signed, addr 0x...03, rd_data 0x80FF_0000 → load_data 0xFFFF_FF80. Same access unsigned → 0x0000_0080.
- Store half, addr 0x...02, rs2 0x1234_ABCD → wr_data 0xABCD_ABCD, mask 4'b1100, wr_req held until ack; no load_valid.
- Misaligned word load, addr 0x...01 → misaligned_out=1 for one cycle, no bus req, stall=0.
- No ack, TIMEOUT_CYCLES=4 → rd_req high for 4 cycles, then bus_error_out=1 for one cycle, load_valid=0, back to IDLE.
- reset_in asserted mid-BUSY → rd_req/wr_req and stall drop asynchronously; after release, an ack-only input produces no response.
